// File: rtl/pipe_pkg.sv
// Shared pipeline package: NOP, opcodes, IF/ID payload and immediate helpers.
package pipe_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP       = 32'h0000_0013;
    localparam logic [6:0]      OP_JAL    = 7'b1101111;
    localparam logic [6:0]      OP_BRANCH = 7'b1100011;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic            pred_taken;
        logic [XLEN-1:0] pred_pc;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{
        valid:      1'b0,
        inst:       NOP,
        pc:         '0,
        pred_taken: 1'b0,
        pred_pc:    '0
    };

    // J-type immediate, same bit layout as the decode immediate generator
    function automatic logic [XLEN-1:0] imm_j(input logic [XLEN-1:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    // B-type immediate, same bit layout as the decode immediate generator
    function automatic logic [XLEN-1:0] imm_b(input logic [XLEN-1:0] inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus bundle: instruction memory, hazard control and IF/ID outputs.
interface if_stage_if;
    import pipe_pkg::*;

    logic [XLEN-1:0] imem_addr_o;
    logic [XLEN-1:0] imem_rdata_i;
    logic            stall_i;
    logic            flush_i;
    logic [XLEN-1:0] redirect_pc_i;
    logic [XLEN-1:0] if_id_inst_o;
    logic [XLEN-1:0] if_id_pc_o;
    logic            if_id_valid_o;
    logic            if_id_pred_taken_o;
    logic [XLEN-1:0] if_id_pred_pc_o;

    modport master (
        output imem_addr_o,
        input  imem_rdata_i,
        input  stall_i,
        input  flush_i,
        input  redirect_pc_i,
        output if_id_inst_o,
        output if_id_pc_o,
        output if_id_valid_o,
        output if_id_pred_taken_o,
        output if_id_pred_pc_o
    );

    modport slave (
        input  imem_addr_o,
        output imem_rdata_i,
        output stall_i,
        output flush_i,
        output redirect_pc_i,
        input  if_id_inst_o,
        input  if_id_pc_o,
        input  if_id_valid_o,
        input  if_id_pred_taken_o,
        input  if_id_pred_pc_o
    );

endinterface

// File: rtl/if_predict.sv
// Static predictor: JAL always taken, B-type taken only when backward.
module if_predict
    import pipe_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] inst,
    output logic            taken,
    output logic [XLEN-1:0] target
);

    // Decode opcode and form the predicted target
    always_comb begin
        taken  = 1'b0;
        target = pc + 32'd4;
        case (inst[6:0])
            OP_JAL: begin
                taken  = 1'b1;
                target = pc + imm_j(inst);
            end
            OP_BRANCH: begin
                taken  = inst[31];
                target = pc + imm_b(inst);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, next-PC selection and IF/ID register.
// Optional static prediction enabled by defining IF_STATIC_PREDICT_EN.
module if_stage
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    if_stage_if.master  bus
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_next;
    if_id_t          if_id_q;
    logic            pred_taken;

`ifdef IF_STATIC_PREDICT_EN
    logic [XLEN-1:0] pred_target;

    if_predict u_predict (
        .pc     (pc_q),
        .inst   (bus.imem_rdata_i),
        .taken  (pred_taken),
        .target (pred_target)
    );
`else
    assign pred_taken = 1'b0;
`endif

    // Next-PC priority: redirect, stall, prediction, sequential (wraps mod 2^32)
    always_comb begin
        pc_next = pc_q + 32'd4;
        if (bus.flush_i) begin
            pc_next = {bus.redirect_pc_i[31:2], 2'b00};
        end else if (bus.stall_i) begin
            pc_next = pc_q;
        end
`ifdef IF_STATIC_PREDICT_EN
        else if (pred_taken) begin
            pc_next = pred_target;
        end
`endif
    end

    // PC and IF/ID register; flush inserts a bubble even while stalled
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q    <= RESET_PC;
            if_id_q <= IF_ID_BUBBLE;
        end else if (bus.flush_i) begin
            pc_q    <= pc_next;
            if_id_q <= IF_ID_BUBBLE;
        end else if (!bus.stall_i) begin
            pc_q    <= pc_next;
            if_id_q <= '{
                valid:      1'b1,
                inst:       bus.imem_rdata_i,
                pc:         pc_q,
                pred_taken: pred_taken,
                pred_pc:    pc_next
            };
        end
    end

    assign bus.imem_addr_o        = pc_q;
    assign bus.if_id_inst_o       = if_id_q.inst;
    assign bus.if_id_pc_o         = if_id_q.pc;
    assign bus.if_id_valid_o      = if_id_q.valid;
    assign bus.if_id_pred_taken_o = if_id_q.pred_taken;
    assign bus.if_id_pred_pc_o    = if_id_q.pred_pc;

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the fetch address loaded on reset.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port imem_addr_o, output, 32 bits: fetch address, driven directly from the PC register.
REQ-005 SHALL have port imem_rdata_i, input, 32 bits: instruction word; combinational read, valid in the same cycle as imem_addr_o.
REQ-006 SHALL have port stall_i, input, 1 bit: hazard stall; holds the PC and the IF/ID register.
REQ-007 SHALL have port flush_i, input, 1 bit: redirect request from execute (mispredict or jump).
REQ-008 SHALL have port redirect_pc_i, input, 32 bits: corrected PC; sampled only when flush_i=1.
REQ-009 SHALL have port if_id_inst_o, output, 32 bits: registered instruction fed to decode and immediate generation.
REQ-010 SHALL have port if_id_pc_o, output, 32 bits: registered PC of if_id_inst_o.
REQ-011 SHALL have port if_id_valid_o, output, 1 bit: 1 = if_id_inst_o is a real instruction.
REQ-012 SHALL have port if_id_pred_taken_o, output, 1 bit: fetch predicted this instruction taken.
REQ-013 SHALL have port if_id_pred_pc_o, output, 32 bits: the next PC fetch chose after this instruction.

Function
REQ-014 SHALL compute pc_next with this priority: flush_i gives {redirect_pc_i[31:2],2'b00}; else stall_i gives pc_q; else predicted-taken gives pred_target; else pc_q+4.
REQ-015 SHALL perform all PC arithmetic modulo 2^32; 32'hFFFF_FFFC+4 SHALL wrap to 32'h0000_0000.
REQ-016 SHALL, on flush_i=1 (regardless of stall_i), load IF/ID with valid=0, inst=NOP, pred_taken=0, pc and pred_pc=0.
REQ-017 SHALL, on stall_i=1 with flush_i=0, hold pc_q and all IF/ID outputs unchanged.
REQ-018 SHALL, otherwise, load IF/ID with imem_rdata_i, pc_q, valid=1, pred_taken and pred_pc=pc_next; fetch-to-decode latency is 1 cycle.
REQ-019 SHALL always present NOP on if_id_inst_o when if_id_valid_o=0.
REQ-020 SHALL form pred_target as pc_q plus the sign-extended J-immediate for opcode 1101111 and the sign-extended B-immediate for opcode 1100011; the bit layouts SHALL be identical to the decode-stage immediate generator.

Reset
REQ-021 SHALL, while rst_i=1, immediately force pc_q=RESET_PC, if_id_valid_o=0, if_id_inst_o=NOP, if_id_pc_o=0, if_id_pred_taken_o=0 and if_id_pred_pc_o=0.
REQ-022 SHALL, on the first clock edge after rst_i deasserts, fetch RESET_PC; reset asserted mid-stall or mid-flush SHALL override both.

Configuration
REQ-023 SHALL support macro IF_STATIC_PREDICT_EN.
- Defined: JAL is predicted taken; B-type is predicted taken when inst[31]=1 (backward) and not taken otherwise.
- Undefined: pred_taken is constant 0, pc_next never uses pred_target, and the predictor logic is not instantiated.

Structure
REQ-024 SHALL take these items from the shared package pipe_pkg: NOP constant 32'h0000_0013, opcode constants OP_JAL and OP_BRANCH, and the IF/ID payload struct type.
REQ-025 SHALL place the combinational predictor in sub-module if_predict (inputs pc and inst; outputs taken and target).

Verification
REQ-026 SHALL cover reset release with RESET_PC=0 and no stalls: imem_addr_o sequence 0,4,8; IF/ID valid from cycle 2, with if_id_pc_o=0 then 4.
REQ-027 SHALL cover stall_i=1 for 3 cycles at pc=0x10: imem_addr_o=0x10 and IF/ID frozen throughout; 0x14 fetched after release.
REQ-028 SHALL cover flush_i=1 with stall_i=1 and redirect_pc_i=0x103: next imem_addr_o=0x100 and if_id_valid_o=0 with inst=NOP.
REQ-029 SHALL cover predictor on: inst 0xFE000EE3 (beq x0,x0,-4) at 0x20 gives next fetch 0x1C and pred_taken=1; a forward beq gives 0x24; with the macro undefined both give 0x24.
REQ-030 SHALL cover wrap-around: pc=0xFFFF_FFFC with no branch gives next fetch 0x0000_0000.
REQ-031 SHALL cover rst_i asserted asynchronously mid-cycle during a stall: outputs clear before the next edge and pc=RESET_PC.
